// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer
// T-state / M-cycle timing generator feeding the per-instruction microcode ROMs.
// It produces a one-hot T-state step and a one-hot M-cycle count. The count
// restarts when the active microcode requests an opcode fetch. The block also
// handles HALT entry and wake, clock-enable stalls and instruction-length reporting.
module cpu_cycle_sequencer #(
  parameter int MAX_MCYCLES = 8,
  parameter int STEPS       = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Clock_Enable,
  input  logic                   i_IR_Fetch,
  input  logic                   i_Halt,
  input  logic                   i_Wake,
  output logic [STEPS-1:0]       o_Cycle_Step,
  output logic [MAX_MCYCLES-1:0] o_Cycle_Count,
  output logic                   o_Instruction_Start,
  output logic [3:0]             o_Last_Length,
  output logic                   o_Halted,
  output logic                   o_Overrun
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [STEPS-1:0]       STEP_T1     = {{(STEPS-1){1'b0}}, 1'b1};
  localparam logic [MAX_MCYCLES-1:0] COUNT_FIRST = {{(MAX_MCYCLES-1){1'b0}}, 1'b1};
  localparam logic [3:0]             LEN_MAX     = 4'(MAX_MCYCLES);

  // Length of an instruction whose last M-cycle is the given one-hot count bit.
  function automatic logic [3:0] onehot_len(input logic [MAX_MCYCLES-1:0] cnt);
    logic [3:0] len;
    len = 4'd0;
    for (int i = 0; i < MAX_MCYCLES; i++) begin
      if (cnt[i]) begin
        len = 4'(i + 1);
      end
    end
    return len;
  endfunction

  state_t                   state_r, state_nxt_s;
  logic [STEPS-1:0]         step_r, step_nxt_s;
  logic [MAX_MCYCLES-1:0]   count_r, count_nxt_s;
  logic                     start_r, start_nxt_s;
  logic [3:0]               last_len_r, last_len_nxt_s;
  logic                     halted_r, halted_nxt_s;
  logic                     overrun_r, overrun_nxt_s;
  logic                     fetch_seen_r, fetch_seen_nxt_s;
  logic                     wake_pend_r, wake_pend_nxt_s;
  logic                     fetch_s;
  logic                     boundary_s;

  // A fetch request anywhere in this M-cycle, including the current clock.
  assign fetch_s    = fetch_seen_r | i_IR_Fetch;
  assign boundary_s = step_r[STEPS-1];

  // State register; a stalled clock leaves the state untouched.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_r <= ST_RUN;
    end else if (i_Clock_Enable) begin
      state_r <= state_nxt_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Next-state decision: HALT on a fetch boundary flagged as HALT, RUN again on wake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (boundary_s && fetch_s && i_Halt) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (i_Wake || wake_pend_r) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Next values of the timing, length and status registers.
  always_comb begin
    step_nxt_s       = step_r;
    count_nxt_s      = count_r;
    start_nxt_s      = 1'b0;
    last_len_nxt_s   = last_len_r;
    halted_nxt_s     = halted_r;
    overrun_nxt_s    = overrun_r;
    fetch_seen_nxt_s = fetch_seen_r;
    wake_pend_nxt_s  = wake_pend_r;
    case (state_r)
      ST_RUN: begin
        step_nxt_s = {step_r[STEPS-2:0], step_r[STEPS-1]};
        if (boundary_s) begin
          fetch_seen_nxt_s = 1'b0;
          if (fetch_s) begin
            count_nxt_s    = COUNT_FIRST;
            last_len_nxt_s = onehot_len(count_r);
            if (i_Halt) begin
              step_nxt_s      = STEP_T1;
              halted_nxt_s    = 1'b1;
              // A wake arriving with the HALT itself still costs one HALT clock.
              wake_pend_nxt_s = i_Wake;
            end else begin
              start_nxt_s = 1'b1;
            end
          end else if (count_r[MAX_MCYCLES-1]) begin
            // Ran off the end of the count without a fetch: force a refetch.
            count_nxt_s    = COUNT_FIRST;
            overrun_nxt_s  = 1'b1;
            last_len_nxt_s = LEN_MAX;
          end else begin
            count_nxt_s = count_r << 1'b1;
          end
        end else begin
          fetch_seen_nxt_s = fetch_s;
        end
      end
      ST_HALT: begin
        step_nxt_s       = STEP_T1;
        count_nxt_s      = COUNT_FIRST;
        fetch_seen_nxt_s = 1'b0;
        if (i_Wake || wake_pend_r) begin
          halted_nxt_s    = 1'b0;
          start_nxt_s     = 1'b1;
          wake_pend_nxt_s = 1'b0;
        end else begin
          halted_nxt_s = 1'b1;
        end
      end
      default: begin
        step_nxt_s  = STEP_T1;
        count_nxt_s = COUNT_FIRST;
      end
    endcase
  end

  // Timing/status registers, held on stalled clocks.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      step_r       <= STEP_T1;
      count_r      <= COUNT_FIRST;
      start_r      <= 1'b1;
      last_len_r   <= 4'd0;
      halted_r     <= 1'b0;
      overrun_r    <= 1'b0;
      fetch_seen_r <= 1'b0;
      wake_pend_r  <= 1'b0;
    end else if (i_Clock_Enable) begin
      step_r       <= step_nxt_s;
      count_r      <= count_nxt_s;
      start_r      <= start_nxt_s;
      last_len_r   <= last_len_nxt_s;
      halted_r     <= halted_nxt_s;
      overrun_r    <= overrun_nxt_s;
      fetch_seen_r <= fetch_seen_nxt_s;
      wake_pend_r  <= wake_pend_nxt_s;
    end else begin
      step_r       <= step_r;
      count_r      <= count_r;
      start_r      <= start_r;
      last_len_r   <= last_len_r;
      halted_r     <= halted_r;
      overrun_r    <= overrun_r;
      fetch_seen_r <= fetch_seen_r;
      wake_pend_r  <= wake_pend_r;
    end
  end

  // Output drive; the start pulse is held through a stall but masked while stalled.
  always_comb begin
    o_Cycle_Step        = step_r;
    o_Cycle_Count       = count_r;
    o_Instruction_Start = start_r & i_Clock_Enable;
    o_Last_Length       = last_len_r;
    o_Halted            = halted_r;
    o_Overrun           = overrun_r;
  end

endmodule
